// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl
//   APB master that brings up a UART APB slave (divisor, line control, FIFO
//   control, interrupt enable) and then runs a polling scheduler that
//   shares the single APB port between feeding the transmitter from a
//   valid/ready byte client and draining the receiver into a one-entry
//   holding register.
//
//   Optional feature macro: UART_HOST_RX_EN
//     defined   : RX path, holding register and RX/TX arbitration.
//     undefined : TX only; rx outputs are constant zero, i_rx_ready ignored.
//
//   Ports
//     i_clk, i_rst        clock, asynchronous active-high reset
//     i_init_start        pulse: (re)start the init sequence
//     i_div_const[15:0]   divisor latch value, sampled on i_init_start
//     i_lcr_cfg[6:0]      LCR[6:0], sampled on i_init_start
//     o_init_done         high while running the polling scheduler
//     o_err               sticky slave error, cleared by i_init_start
//     i_tx_valid/o_tx_ready/i_tx_data   byte stream toward UART TX
//     o_rx_valid/i_rx_ready/o_rx_data   byte stream from UART RX
//     o_rx_lsr[3:0]       LSR[4:1] captured with o_rx_data
//     o_psel..o_pwstrb    APB master request (registered)
//     i_pready, i_pslverr, i_prdata     APB slave response
module uart_host_ctrl #(
  parameter int POLL_GAP = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_start,
  input  logic [15:0] i_div_const,
  input  logic [6:0]  i_lcr_cfg,
  output logic        o_init_done,
  output logic        o_err,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  input  logic [7:0]  i_tx_data,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic [7:0]  o_rx_data,
  output logic [3:0]  o_rx_lsr,
  output logic        o_psel,
  output logic        o_penable,
  output logic        o_pwrite,
  output logic [11:0] o_paddr,
  output logic [31:0] o_pwdata,
  output logic [3:0]  o_pwstrb,
  input  logic        i_pready,
  input  logic        i_pslverr,
  input  logic [31:0] i_prdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_POLL, S_GAP, S_TXW, S_RXR
  } state_t;

  localparam logic [2:0] IDX_RHR = 3'd0;
  localparam logic [2:0] IDX_LSR = 3'd5;

  // Register index written by each init step.
  function automatic logic [2:0] f_init_idx(input logic [2:0] step);
    case (step)
      3'd0:    f_init_idx = 3'd3;
      3'd1:    f_init_idx = 3'd0;
      3'd2:    f_init_idx = 3'd1;
      3'd3:    f_init_idx = 3'd3;
      3'd4:    f_init_idx = 3'd2;
      default: f_init_idx = 3'd1;
    endcase
  endfunction

  // Byte written by each init step; step 0 opens the divisor latch.
  function automatic logic [7:0] f_init_byte(input logic [2:0]  step,
                                             input logic [15:0] dv,
                                             input logic [6:0]  lc);
    case (step)
      3'd0:    f_init_byte = 8'h80;
      3'd1:    f_init_byte = dv[7:0];
      3'd2:    f_init_byte = dv[15:8];
      3'd3:    f_init_byte = {1'b0, lc};
      3'd4:    f_init_byte = 8'h07;
      default: f_init_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] f_lane(input logic [31:0] d, input logic [1:0] l);
    case (l)
      2'd0:    f_lane = d[7:0];
      2'd1:    f_lane = d[15:8];
      2'd2:    f_lane = d[23:16];
      default: f_lane = d[31:24];
    endcase
  endfunction

  state_t      r_state, nxt_state;
  logic [2:0]  r_step, nxt_step;
  logic        r_psel, nxt_psel;
  logic        r_penable, nxt_penable;
  logic        r_pwrite, nxt_pwrite;
  logic [11:0] r_paddr, nxt_paddr;
  logic [31:0] r_pwdata, nxt_pwdata;
  logic [3:0]  r_pwstrb, nxt_pwstrb;
  logic        r_last_rx, nxt_last_rx;
  logic [7:0]  r_gap, nxt_gap;
  logic        r_pend, nxt_pend;
  logic        r_err;
  logic [15:0] r_div;
  logic [6:0]  r_lcr;

  logic        w_done;
  logic [7:0]  w_rd_byte;
  logic        w_tx_ok;
  logic        w_rx_ok;
  logic        w_init_req;
  logic [15:0] w_div;
  logic [6:0]  w_lcr;
  logic        w_start;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic [7:0]  w_byte;
  logic        w_init_go;
  logic        w_rx_load;

  assign w_done     = r_psel & r_penable & i_pready;
  assign w_rd_byte  = f_lane(i_prdata, r_paddr[1:0]);
  assign w_tx_ok    = w_rd_byte[5] & i_tx_valid;
  assign w_init_req = r_pend | i_init_start;
  // A same-cycle init_start must use the live configuration, not the stale copy.
  assign w_div      = i_init_start ? i_div_const : r_div;
  assign w_lcr      = i_init_start ? i_lcr_cfg   : r_lcr;

  always_comb begin
    nxt_state   = r_state;
    nxt_step    = r_step;
    nxt_psel    = r_psel;
    nxt_penable = r_penable;
    nxt_pwrite  = r_pwrite;
    nxt_paddr   = r_paddr;
    nxt_pwdata  = r_pwdata;
    nxt_pwstrb  = r_pwstrb;
    nxt_last_rx = r_last_rx;
    nxt_gap     = r_gap;
    w_start     = 1'b0;
    w_idx       = 3'd0;
    w_wr        = 1'b0;
    w_byte      = 8'h00;
    w_init_go   = 1'b0;
    w_rx_load   = 1'b0;

    if (r_psel && !r_penable) nxt_penable = 1'b1;
    if (w_done) begin
      nxt_psel    = 1'b0;
      nxt_penable = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (i_init_start) w_init_go = 1'b1;
      end
      S_INIT: begin
        if (w_done) begin
          if (w_init_req) begin
            w_init_go = 1'b1;
          end else if (r_step == 3'd5) begin
            nxt_state = S_POLL;
            w_start   = 1'b1;
            w_idx     = IDX_LSR;
          end else begin
            nxt_step = 3'(r_step + 3'd1);
            w_start  = 1'b1;
            w_wr     = 1'b1;
            w_idx    = f_init_idx(3'(r_step + 3'd1));
            w_byte   = f_init_byte(3'(r_step + 3'd1), w_div, w_lcr);
          end
        end
      end
      S_POLL: begin
        if (w_done) begin
          if (w_init_req) begin
            w_init_go = 1'b1;
          end else if (w_rx_ok && (!w_tx_ok || !r_last_rx)) begin
            // RX wins when alone or when TX had the previous grant.
            nxt_state   = S_RXR;
            nxt_last_rx = 1'b1;
            w_start     = 1'b1;
            w_idx       = IDX_RHR;
          end else if (w_tx_ok) begin
            nxt_state   = S_TXW;
            nxt_last_rx = 1'b0;
            w_start     = 1'b1;
            w_wr        = 1'b1;
            w_idx       = 3'd0;
            w_byte      = i_tx_data;
          end else if (POLL_GAP == 0) begin
            w_start = 1'b1;
            w_idx   = IDX_LSR;
          end else begin
            nxt_state = S_GAP;
            nxt_gap   = 8'(POLL_GAP - 1);
          end
        end
      end
      S_GAP: begin
        if (w_init_req) begin
          w_init_go = 1'b1;
        end else if (r_gap == 8'd0) begin
          nxt_state = S_POLL;
          w_start   = 1'b1;
          w_idx     = IDX_LSR;
        end else begin
          nxt_gap = r_gap - 8'd1;
        end
      end
      S_TXW, S_RXR: begin
        if (w_done) begin
          w_rx_load = (r_state == S_RXR);
          if (w_init_req) begin
            w_init_go = 1'b1;
          end else begin
            nxt_state = S_POLL;
            w_start   = 1'b1;
            w_idx     = IDX_LSR;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase

    if (w_init_go) begin
      nxt_state = S_INIT;
      nxt_step  = 3'd0;
      w_start   = 1'b1;
      w_wr      = 1'b1;
      w_idx     = f_init_idx(3'd0);
      w_byte    = f_init_byte(3'd0, w_div, w_lcr);
    end

    if (w_start) begin
      nxt_psel    = 1'b1;
      nxt_penable = 1'b0;
      nxt_pwrite  = w_wr;
      nxt_paddr   = {9'b0, w_idx};
      nxt_pwdata  = w_wr ? {4{w_byte}} : 32'h0;
      nxt_pwstrb  = w_wr ? (4'b0001 << w_idx[1:0]) : 4'b0000;
    end
  end

  always_comb begin
    nxt_pend = r_pend;
    if (w_init_go)         nxt_pend = 1'b0;
    else if (i_init_start) nxt_pend = 1'b1;
  end

  // Stage: control and APB request registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_step    <= 3'd0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 12'h0;
      r_pwdata  <= 32'h0;
      r_pwstrb  <= 4'h0;
      r_last_rx <= 1'b0;
      r_gap     <= 8'd0;
      r_pend    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= nxt_state;
      r_step    <= nxt_step;
      r_psel    <= nxt_psel;
      r_penable <= nxt_penable;
      r_pwrite  <= nxt_pwrite;
      r_paddr   <= nxt_paddr;
      r_pwdata  <= nxt_pwdata;
      r_pwstrb  <= nxt_pwstrb;
      r_last_rx <= nxt_last_rx;
      r_gap     <= nxt_gap;
      r_pend    <= nxt_pend;
      if (i_init_start)              r_err <= 1'b0;
      else if (w_done && i_pslverr)  r_err <= 1'b1;
    end
  end

  // Stage: configuration capture
  always_ff @(posedge i_clk) begin
    if (i_init_start) begin
      r_div <= i_div_const;
      r_lcr <= i_lcr_cfg;
    end
  end

`ifdef UART_HOST_RX_EN
  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic [3:0] r_rx_lsr;
  logic [3:0] r_lsr_p;

  assign w_rx_ok = w_rd_byte[0] & ~r_rx_valid;

  // Stage: RX holding register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_lsr   <= 4'h0;
      r_lsr_p    <= 4'h0;
    end else begin
      if (r_state == S_POLL && w_done) r_lsr_p <= w_rd_byte[4:1];
      if (w_rx_load) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= w_rd_byte;
        r_rx_lsr   <= r_lsr_p;
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;
  assign o_rx_lsr   = r_rx_lsr;
`else
  logic w_unused;

  assign w_rx_ok    = 1'b0;
  assign o_rx_valid = 1'b0;
  assign o_rx_data  = 8'h00;
  assign o_rx_lsr   = 4'h0;
  assign w_unused   = ^{i_rx_ready, w_rx_load, w_rd_byte[7:6], w_rd_byte[4:0]};
`endif

  assign o_init_done = (r_state == S_POLL) || (r_state == S_GAP) ||
                       (r_state == S_TXW)  || (r_state == S_RXR);
  assign o_err       = r_err;
  assign o_tx_ready  = (r_state == S_TXW) && w_done;
  assign o_psel      = r_psel;
  assign o_penable   = r_penable;
  assign o_pwrite    = r_pwrite;
  assign o_paddr     = r_paddr;
  assign o_pwdata    = r_pwdata;
  assign o_pwstrb    = r_pwstrb;

endmodule
